button_cmd_arbiter: RTL

Converts the debounced push-button levels of the cube-solver front panel into a single stream of one-shot command events. It sits between the per-button debouncers and the move/menu controller. Press edges are captured per button and arbitrated round-robin onto one valid/ready command port. An optional hold-to-repeat generator is included.

---
 rtl/button_cmd_arbiter_pkg.sv | 22 ++
 rtl/button_cmd_arbiter_chan.sv | 84 ++++++++
 rtl/button_cmd_arbiter.sv | 106 ++++++++++
 3 files changed

// File: rtl/button_cmd_arbiter_pkg.sv
// Shared front-panel definitions: button count default, button indices,
// arbiter FSM state type and a small sizing helper.
package panel_pkg;

  localparam int unsigned N_BTN_DEFAULT = 5;

  localparam int unsigned BTN_UP     = 0;
  localparam int unsigned BTN_DOWN   = 1;
  localparam int unsigned BTN_LEFT   = 2;
  localparam int unsigned BTN_RIGHT  = 3;
  localparam int unsigned BTN_CENTER = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } arb_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_cmd_arbiter_chan.sv
// Per-button event channel: press-edge capture, pending bit, overrun pulse.
// Hold-to-repeat counter is built only when BTN_AUTOREPEAT_EN is defined.
module btn_event_chan
  import panel_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = 12_500_000,
  parameter int unsigned REPEAT_CYCLES = 5_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic clean_i,
  input  logic lock_i,
  input  logic clr_i,
  output logic pending_o,
  output logic overrun_o
);

  logic prev_q;
  logic pending_q, pending_d;
  logic overrun_q, overrun_d;
  logic press, rpt, evt;

  assign press = clean_i & ~prev_q & ~lock_i;

`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned CNT_W = $clog2(max_u(HOLD_CYCLES, REPEAT_CYCLES) + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             rep_q, rep_d;

  // rep_q selects the target: first HOLD_CYCLES, then every REPEAT_CYCLES
  always_comb begin
    cnt_inc = cnt_q + 1'b1;
    cnt_d   = '0;
    rep_d   = 1'b0;
    rpt     = 1'b0;
    if (clean_i && !lock_i) begin
      cnt_d = cnt_inc;
      rep_d = rep_q;
      if (cnt_inc == (rep_q ? CNT_W'(REPEAT_CYCLES) : CNT_W'(HOLD_CYCLES))) begin
        rpt   = 1'b1;
        cnt_d = '0;
        rep_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q <= '0;
      rep_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      rep_q <= rep_d;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{HOLD_CYCLES, REPEAT_CYCLES};
  assign rpt        = 1'b0;
`endif

  assign evt = press | rpt;

  always_comb begin
    pending_d = evt | (pending_q & ~clr_i);
    overrun_d = evt & pending_q;
  end

  always_ff @(posedge clock) begin
    prev_q <= clean_i;
    if (!reset) begin
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  assign pending_o = pending_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/button_cmd_arbiter.sv
// Front-panel button command arbiter: per-button event channels feeding a
// round-robin valid/ready command port. Auto-repeat via BTN_AUTOREPEAT_EN.
module button_cmd_arbiter
  import panel_pkg::*;
#(
  parameter int unsigned N_BTN         = N_BTN_DEFAULT,
  parameter int unsigned HOLD_CYCLES   = 12_500_000,
  parameter int unsigned REPEAT_CYCLES = 5_000_000,
  localparam int unsigned ID_W         = $clog2(N_BTN)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_BTN-1:0] clean,
  input  logic             lock,
  output logic             cmd_valid,
  output logic [ID_W-1:0]  cmd_id,
  input  logic             cmd_ready,
  output logic             overrun
);

  logic [N_BTN-1:0] pending, ovr, clr;
  arb_state_e       state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic             xfer;
  logic             grant_found;
  logic [ID_W-1:0]  grant_idx;
  int unsigned      idx;

  for (genvar g = 0; g < N_BTN; g++) begin : g_chan
    btn_event_chan #(
      .HOLD_CYCLES   (HOLD_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_chan (
      .clock     (clock),
      .reset     (reset),
      .clean_i   (clean[g]),
      .lock_i    (lock),
      .clr_i     (clr[g]),
      .pending_o (pending[g]),
      .overrun_o (ovr[g])
    );
  end

  assign xfer = (state_q == OFFER) & cmd_ready;

  always_comb begin
    clr = '0;
    if (xfer) clr[id_q] = 1'b1;
  end

  // first pending bit at or after ptr, wrapping past N_BTN-1
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int unsigned k = 0; k < N_BTN; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N_BTN) idx = idx - N_BTN;
      if (!grant_found && pending[idx]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          state_d = OFFER;
          id_d    = grant_idx;
        end
      end
      OFFER: begin
        if (cmd_ready) begin
          state_d = IDLE;
          ptr_d   = (id_q == ID_W'(N_BTN - 1)) ? '0 : id_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_valid = (state_q == OFFER);
    cmd_id    = id_q;
    overrun   = |ovr;
  end

endmodule
